// File: rtl/display_pkg.sv
// Shared types and default raster/object dimensions for the sprite scheduler.
package display_pkg;

    localparam int unsigned COORD_W      = 11;
    localparam int unsigned RGB_W        = 3;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_RECT_W   = 100;
    localparam int unsigned DEF_RECT_H   = 100;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               xd;
        logic               yd;
        logic [RGB_W-1:0]   rgb;
        logic               en;
    } obj_t;

    typedef enum logic {
        IDLE,
        UPDATE
    } state_t;

endpackage

// File: rtl/axis_step.sv
// One-axis bounce step: advance position by one, reflecting at 0 and max_p.
module axis_step #(
    parameter int unsigned W = 11
) (
    input  logic [W-1:0] p,
    input  logic         d,
    input  logic [W-1:0] max_p,
    output logic [W-1:0] p_next,
    output logic         d_next
);

    always_comb begin
        p_next = p;
        d_next = d;
        if (d && (p == max_p)) begin
            p_next = max_p - W'(1);
            d_next = 1'b0;
        end else if (!d && (p == '0)) begin
            p_next = W'(1);
            d_next = 1'b1;
        end else if (d) begin
            p_next = p + W'(1);
        end else begin
            p_next = p - W'(1);
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Bouncing-rectangle object store with a shared end-of-frame update path,
// host config port and per-pixel lowest-index-wins colour arbitration.
module sprite_scheduler
    import display_pkg::*;
#(
    parameter int unsigned NUM_OBJ  = 4,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned RECT_W   = DEF_RECT_W,
    parameter int unsigned RECT_H   = DEF_RECT_H
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                pixelx,
    input  logic [10:0]                pixely,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(NUM_OBJ)-1:0] cfg_idx,
    input  logic [10:0]                cfg_x,
    input  logic [10:0]                cfg_y,
    input  logic                       cfg_xd,
    input  logic                       cfg_yd,
    input  logic [2:0]                 cfg_rgb,
    input  logic                       cfg_en,
    output logic                       busy,
    output logic                       r,
    output logic                       g,
    output logic                       b
);

    localparam int unsigned IDX_W = $clog2(NUM_OBJ);
    localparam logic [COORD_W-1:0] XMAX   = COORD_W'(H_ACTIVE - RECT_W);
    localparam logic [COORD_W-1:0] YMAX   = COORD_W'(V_ACTIVE - RECT_H);
    localparam logic [COORD_W-1:0] RW     = COORD_W'(RECT_W);
    localparam logic [COORD_W-1:0] RH     = COORD_W'(RECT_H);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(V_ACTIVE - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);

    localparam obj_t OBJ0_RST = '{x: COORD_W'(50), y: COORD_W'(50), xd: 1'b1, yd: 1'b1,
                                  rgb: 3'b100, en: 1'b1};
    localparam obj_t OBJN_RST = '{x: '0, y: '0, xd: 1'b1, yd: 1'b1, rgb: 3'b000, en: 1'b0};

    state_t             state;
    logic [IDX_W-1:0]   idx;
    obj_t               objs [NUM_OBJ];
    obj_t               cur;
    obj_t               cfg_obj;
    logic               frame_end;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic               nxd;
    logic               nyd;
    logic [RGB_W-1:0]   pix_rgb;

    assign frame_end = (pixelx == LAST_X) && (pixely == LAST_Y);
    assign cfg_ready = (state == IDLE) && !frame_end;
    assign cur       = objs[idx];

    // Shared update datapath, fed from the object selected by idx
    axis_step #(.W(COORD_W)) u_step_x (
        .p      (cur.x),
        .d      (cur.xd),
        .max_p  (XMAX),
        .p_next (nx),
        .d_next (nxd)
    );

    axis_step #(.W(COORD_W)) u_step_y (
        .p      (cur.y),
        .d      (cur.yd),
        .max_p  (YMAX),
        .p_next (ny),
        .d_next (nyd)
    );

    // Host write payload with positions clamped into the legal travel range
    always_comb begin
        cfg_obj     = '0;
        cfg_obj.x   = (cfg_x > XMAX) ? XMAX : cfg_x;
        cfg_obj.y   = (cfg_y > YMAX) ? YMAX : cfg_y;
        cfg_obj.xd  = cfg_xd;
        cfg_obj.yd  = cfg_yd;
        cfg_obj.rgb = cfg_rgb;
        cfg_obj.en  = cfg_en;
    end

    // Priority encoder: scanning downward lets the lowest-index hit overwrite
    always_comb begin
        pix_rgb = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (objs[i].en &&
                (pixelx >= objs[i].x) && (pixelx < objs[i].x + RW) &&
                (pixely >= objs[i].y) && (pixely < objs[i].y + RH)) begin
                pix_rgb = objs[i].rgb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            r     <= 1'b0;
            g     <= 1'b0;
            b     <= 1'b0;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                objs[i] <= (i == 0) ? OBJ0_RST : OBJN_RST;
            end
        end else begin
            {r, g, b} <= pix_rgb;
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        state <= UPDATE;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else if (cfg_valid) begin
                        objs[cfg_idx] <= cfg_obj;
                    end
                end
                UPDATE: begin
                    if (cur.en) begin
                        objs[idx].x  <= nx;
                        objs[idx].xd <= nxd;
                        objs[idx].y  <= ny;
                        objs[idx].yd <= nyd;
                    end
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: behavioural object model,
// pixel scoreboard, vector table and hand-written frame/reset sequences.
module tb_sprite_scheduler;

    localparam int N    = 4;
    localparam int XMAX = 540;
    localparam int YMAX = 380;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pixelx, pixely;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_x, cfg_y;
    logic        cfg_xd, cfg_yd, cfg_en;
    logic [2:0]  cfg_rgb;
    logic        busy, r, g, b;

    sprite_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .pixelx    (pixelx),
        .pixely    (pixely),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_x     (cfg_x),
        .cfg_y     (cfg_y),
        .cfg_xd    (cfg_xd),
        .cfg_yd    (cfg_yd),
        .cfg_rgb   (cfg_rgb),
        .cfg_en    (cfg_en),
        .busy      (busy),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int       m_x [N];
    int       m_y [N];
    bit       m_xd[N];
    bit       m_yd[N];
    bit [2:0] m_rgb[N];
    bit       m_en[N];

    logic [2:0] exp_q[$];

    typedef struct {
        int         px;
        int         py;
        logic [2:0] rgb;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_xd[i] = 1; m_yd[i] = 1; m_rgb[i] = 3'b000; m_en[i] = 0;
        end
        m_x[0] = 50; m_y[0] = 50; m_rgb[0] = 3'b100; m_en[0] = 1;
    endtask

    task automatic ax(inout int p, inout bit d, input int mx);
        if (d) begin
            if (p == mx) begin p = mx - 1; d = 0; end
            else p = p + 1;
        end else begin
            if (p == 0) begin p = 1; d = 1; end
            else p = p - 1;
        end
    endtask

    task automatic model_frame();
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                ax(m_x[i], m_xd[i], XMAX);
                ax(m_y[i], m_yd[i], YMAX);
            end
        end
    endtask

    function automatic logic [2:0] model_rgb(input int px, input int py);
        logic [2:0] res = 3'b000;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_en[i] && px >= m_x[i] && px < m_x[i] + 100 &&
                py >= m_y[i] && py < m_y[i] + 100)
                res = m_rgb[i];
        end
        return res;
    endfunction

    task automatic check_obj(input int i);
        check($sformatf("obj%0d_x", i),   32'(dut.objs[i].x),   32'(m_x[i]));
        check($sformatf("obj%0d_y", i),   32'(dut.objs[i].y),   32'(m_y[i]));
        check($sformatf("obj%0d_xd", i),  32'(dut.objs[i].xd),  32'(m_xd[i]));
        check($sformatf("obj%0d_yd", i),  32'(dut.objs[i].yd),  32'(m_yd[i]));
        check($sformatf("obj%0d_rgb", i), 32'(dut.objs[i].rgb), 32'(m_rgb[i]));
        check($sformatf("obj%0d_en", i),  32'(dut.objs[i].en),  32'(m_en[i]));
    endtask

    // Drive one pixel, queue the model colour, compare when the registered output appears
    task automatic pix(input int px, input int py, input string nm);
        logic [2:0] exp;
        pixelx = 11'(px);
        pixely = 11'(py);
        exp_q.push_back(model_rgb(px, py));
        tick();
        exp = exp_q.pop_front();
        check(nm, 32'({r, g, b}), 32'(exp));
    endtask

    task automatic set_cfg(input int idx, input int x, input int y, input bit xd,
                           input bit yd, input bit [2:0] rgb, input bit en);
        cfg_idx = 2'(idx); cfg_x = 11'(x); cfg_y = 11'(y);
        cfg_xd = xd; cfg_yd = yd; cfg_rgb = rgb; cfg_en = en;
    endtask

    task automatic model_write(input int idx, input int x, input int y, input bit xd,
                               input bit yd, input bit [2:0] rgb, input bit en);
        m_x[idx] = (x > XMAX) ? XMAX : x;
        m_y[idx] = (y > YMAX) ? YMAX : y;
        m_xd[idx] = xd; m_yd[idx] = yd; m_rgb[idx] = rgb; m_en[idx] = en;
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input bit xd,
                             input bit yd, input bit [2:0] rgb, input bit en);
        int n = 0;
        set_cfg(idx, x, y, xd, yd, rgb, en);
        cfg_valid = 1'b1;
        #1;
        while (!cfg_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        model_write(idx, x, y, xd, yd, rgb, en);
    endtask

    // Raise frame_end for one cycle, check the busy window and cfg_ready gating
    task automatic run_frame(input bit hold_cfg);
        pixelx = 11'd639;
        pixely = 11'd479;
        if (hold_cfg) cfg_valid = 1'b1;
        #1;
        check("fe_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        pixelx = 11'd0;
        pixely = 11'd0;
        for (int k = 1; k <= N; k++) begin
            #1;
            check($sformatf("busy_T%0d", k), 32'(busy), 32'd1);
            check($sformatf("ready_T%0d", k), 32'(cfg_ready), 32'd0);
            tick();
        end
        #1;
        check("busy_end", 32'(busy), 32'd0);
        check("ready_end", 32'(cfg_ready), 32'd1);
        model_frame();
        if (hold_cfg) begin
            tick();
            cfg_valid = 1'b0;
        end
    endtask

    initial begin
        int rows[6] = '{0, 49, 50, 100, 149, 150};

        rst = 1'b1; pixelx = '0; pixely = '0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 3'b000, 0);
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        for (int i = 0; i < N; i++) check_obj(i);

        // Raster sweep over rows around the reset-position rectangle
        foreach (rows[k])
            for (int x = 0; x < 640; x++) pix(x, rows[k], $sformatf("sweep_y%0d", rows[k]));

        run_frame(0);
        check_obj(0);
        pix(50, 51, "f1_left_out");
        pix(51, 51, "f1_corner_in");
        pix(150, 150, "f1_br_in");
        pix(151, 151, "f1_br_out");

        cfg_write(0, 540, 51, 1, 1, 3'b100, 1);
        run_frame(0);
        check_obj(0);

        cfg_write(0, 50, 0, 1, 0, 3'b100, 1);
        run_frame(0);
        check_obj(0);

        cfg_write(0, 50, 50, 1, 1, 3'b100, 1);
        cfg_write(1, 100, 100, 1, 1, 3'b010, 1);
        check_obj(1);
        vecs[0] = '{120, 120, 3'b100};
        vecs[1] = '{200, 200, 3'b000};
        vecs[2] = '{199, 199, 3'b010};
        vecs[3] = '{150, 150, 3'b010};
        vecs[4] = '{149, 149, 3'b100};
        vecs[5] = '{49, 50, 3'b000};
        vecs[6] = '{50, 50, 3'b100};
        vecs[7] = '{100, 99, 3'b100};
        vecs[8] = '{100, 150, 3'b010};
        foreach (vecs[k]) begin
            logic [2:0] exp;
            pixelx = 11'(vecs[k].px);
            pixely = 11'(vecs[k].py);
            exp_q.push_back(vecs[k].rgb);
            tick();
            exp = exp_q.pop_front();
            check($sformatf("ovl_%0d_%0d", vecs[k].px, vecs[k].py), 32'({r, g, b}), 32'(exp));
        end

        // Write held across frame_end: lands after the sequence, unstepped
        set_cfg(2, 300, 200, 1, 1, 3'b001, 1);
        run_frame(1);
        model_write(2, 300, 200, 1, 1, 3'b001, 1);
        check_obj(1);
        check_obj(2);
        pix(300, 200, "coll_pix");

        cfg_write(3, 1000, 900, 0, 0, 3'b011, 0);
        check_obj(3);

        // Reset asserted while the update sequence is at idx 2
        pixelx = 11'd639;
        pixely = 11'd479;
        tick();
        pixelx = 11'd151;
        pixely = 11'd151;
        tick();
        tick();
        check("mid_idx", 32'(dut.idx), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_rgb_nz", 32'({r, g, b} != 3'b000), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rgb", 32'({r, g, b}), 32'd0);
        for (int i = 0; i < N; i++) check_obj(i);
        tick();
        rst = 1'b0;
        pixelx = 11'd0;
        pixely = 11'd0;
        tick();
        pix(120, 120, "post_rst_obj0");
        pix(160, 160, "post_rst_obj1_off");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
